display_ascii_sender: RTL and testbench
=======================================

DISPLAY_ASCII_SENDER -- requirements
Module: display_ascii_sender

Interface
REQ-001 SHALL have parameter AUTO_PERIOD, default 100_000_000, meaning clk cycles between automatic frame requests.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, meaning max clk cycles to wait for i_tx_busy to rise after o_tx_start.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_display_data  input  16  four BCD digits, [15:12] most significant.
REQ-006 SHALL have port i_send  input  1  one-cycle frame request pulse.
REQ-007 SHALL have port i_auto_en  input  1  level; enables periodic requests.
REQ-008 SHALL have port i_tx_busy  input  1  UART transmitter busy level.
REQ-009 SHALL have port o_tx_data  output  8  byte presented to the UART transmitter.
REQ-010 SHALL have port o_tx_start  output  1  one-cycle transmit strobe.
REQ-011 SHALL have port o_busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port o_frame_done  output  1  one-cycle pulse after the last byte completes.
REQ-013 SHALL have port o_err  output  1  one-cycle pulse on ACK timeout abort.

Function
REQ-014 Frame SHALL be 7 bytes in order: ASCII(d3), ASCII(d2), 0x3A ':', ASCII(d1), ASCII(d0), 0x0D, 0x0A.
REQ-015 Digit 0-9 SHALL map to 0x30+digit; digit 10-15 SHALL map to 0x2D '-'.
REQ-016 i_display_data SHALL be snapshotted at the edge a frame starts; later input changes SHALL NOT affect that frame.
REQ-017 FSM states SHALL be IDLE, START, WAIT_ACK, WAIT_DONE.
REQ-018 IDLE -> START when a request (i_send, auto tick, or pending flag) is present; byte index set to 0.
REQ-019 In START, o_tx_start SHALL be 1 for exactly one cycle with o_tx_data valid; next state WAIT_ACK.
REQ-020 WAIT_ACK -> WAIT_DONE when i_tx_busy=1; timeout counter resets on entry.
REQ-021 WAIT_ACK reaching ACK_TIMEOUT cycles without i_tx_busy SHALL abort: pulse o_err, go IDLE, discard remaining bytes, no o_frame_done.
REQ-022 WAIT_DONE -> START with index+1 when i_tx_busy=0 and index<6; when index=6 -> IDLE with o_frame_done pulsed one cycle.
REQ-023 o_tx_data SHALL hold the current byte from START through WAIT_DONE.
REQ-024 o_busy SHALL be 1 in every state except IDLE.
REQ-025 Latency: i_send high at edge k (IDLE) -> o_tx_start high in cycle following edge k.
REQ-026 A request arriving while o_busy=1 SHALL set a single pending flag; multiple requests SHALL collapse into one; pending frame starts from IDLE on the next edge.
REQ-027 Auto counter SHALL count clk cycles while i_auto_en=1, wrap at AUTO_PERIOD-1 and raise a request; i_auto_en=0 SHALL clear it to 0.
REQ-028 Simultaneous i_send and auto tick SHALL produce one request.

Reset
REQ-029 rst SHALL force state IDLE, index 0, pending 0, counters 0, o_tx_data 0x00, o_tx_start 0, o_busy 0, o_frame_done 0, o_err 0.
REQ-030 rst asserted mid-frame SHALL abort immediately; no further o_tx_start until a new request after rst release.

Verification
REQ-031 i_display_data=16'h1234, i_send pulse, TX model busy 10 cycles per byte -> bytes 0x31,0x32,0x3A,0x33,0x34,0x0D,0x0A, then one o_frame_done.
REQ-032 i_display_data=16'h9AF0 -> bytes 0x39,0x2D,0x3A,0x2D,0x30,0x0D,0x0A.
REQ-033 i_tx_busy held 0 after first o_tx_start -> o_err pulse after ACK_TIMEOUT cycles, o_busy falls, single o_tx_start seen.
REQ-034 Three i_send pulses during a frame -> exactly two frames total; i_display_data change mid-frame appears only in second frame.
REQ-035 AUTO_PERIOD=50, i_auto_en=1 -> frame starts every 50 cycles when TX idle; i_auto_en=0 -> no new frames.
REQ-036 rst asserted during byte 3 -> all outputs reset values next cycle, no o_frame_done, idle until next i_send.

Source files
------------

// File: rtl/display_ascii_sender.sv
// rtl/display_ascii_sender.sv - sends a 4-digit BCD value as an ASCII "dd:dd\r\n" frame to a UART
module display_ascii_sender #(
  parameter int AUTO_PERIOD = 100_000_000,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_display_data,
  input  logic        i_send,
  input  logic        i_auto_en,
  input  logic        i_tx_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_err
);

  localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
  localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [2:0]    LAST_IDX  = 3'd6;

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

  state_t          state;
  logic [2:0]      idx;
  logic [15:0]     snap;
  logic            pending;
  logic [AW-1:0]   auto_cnt;
  logic [TW-1:0]   ack_cnt;
  logic            auto_tick;
  logic            new_req;

  // Non-decimal nibbles are shown as a dash so a bad value is visible on the terminal.
  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? {4'h3, d} : 8'h2D;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [15:0] data, input logic [2:0] i);
    case (i)
      3'd0:    return digit_ascii(data[15:12]);
      3'd1:    return digit_ascii(data[11:8]);
      3'd2:    return 8'h3A;
      3'd3:    return digit_ascii(data[7:4]);
      3'd4:    return digit_ascii(data[3:0]);
      3'd5:    return 8'h0D;
      3'd6:    return 8'h0A;
      default: return 8'h00;
    endcase
  endfunction

  assign auto_tick = i_auto_en && (auto_cnt == AUTO_LAST);
  assign new_req   = i_send || auto_tick;

  // Free-running period counter; disabling auto mode restarts the period from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_cnt <= '0;
    end else if (!i_auto_en || auto_tick) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end

  // Frame sequencer: one START/WAIT_ACK/WAIT_DONE round trip per byte, all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      snap         <= '0;
      pending      <= 1'b0;
      ack_cnt      <= '0;
      o_tx_data    <= 8'h00;
      o_tx_start   <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_tx_start   <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
      // Requests during a frame collapse into a single follow-up frame.
      if (state != IDLE && new_req) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (new_req || pending) begin
            state      <= START;
            idx        <= '0;
            snap       <= i_display_data;
            o_tx_data  <= frame_byte(i_display_data, 3'd0);
            o_tx_start <= 1'b1;
            o_busy     <= 1'b1;
            pending    <= 1'b0;
          end
        end
        START: begin
          state   <= WAIT_ACK;
          ack_cnt <= '0;
        end
        WAIT_ACK: begin
          if (i_tx_busy) begin
            state <= WAIT_DONE;
          end else if (ack_cnt == ACK_LAST) begin
            state  <= IDLE;
            idx    <= '0;
            o_busy <= 1'b0;
            o_err  <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!i_tx_busy) begin
            if (idx == LAST_IDX) begin
              state        <= IDLE;
              idx          <= '0;
              o_busy       <= 1'b0;
              o_frame_done <= 1'b1;
            end else begin
              state      <= START;
              idx        <= idx + 3'd1;
              o_tx_data  <= frame_byte(snap, idx + 3'd1);
              o_tx_start <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_ascii_sender.sv
// tb/tb_display_ascii_sender.sv - directed self-checking bench for display_ascii_sender
module tb_display_ascii_sender;

  logic        clk;
  logic        rst;
  logic [15:0] i_display_data;
  logic        i_send;
  logic        i_auto_en;
  logic        i_tx_busy;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_err;

  display_ascii_sender #(.AUTO_PERIOD(50), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .i_display_data(i_display_data), .i_send(i_send),
    .i_auto_en(i_auto_en), .i_tx_busy(i_tx_busy), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err(o_err)
  );

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int hold_bad = 0;
  int last_start_cyc = 0;
  int err_cyc = 0;
  int busy_left = 0;
  int busy_len = 10;
  bit tx_en = 1'b1;
  bit prev_busy = 1'b0;
  logic [7:0] bytes[$];
  int fstart[$];

  logic [7:0] f1234[7] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h0D, 8'h0A};
  logic [7:0] f9af0[7] = '{8'h39, 8'h2D, 8'h3A, 8'h2D, 8'h30, 8'h0D, 8'h0A};
  logic [7:0] f5678[7] = '{8'h35, 8'h36, 8'h3A, 8'h37, 8'h38, 8'h0D, 8'h0A};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // UART model: goes busy one cycle after a strobe and stays busy busy_len cycles.
  always @(negedge clk) begin
    if (busy_left > 0) begin
      i_tx_busy = 1'b1;
      busy_left--;
    end else begin
      i_tx_busy = 1'b0;
    end
    if (tx_en && o_tx_start && !rst) busy_left = busy_len;
  end

  // Output monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_tx_start) begin
        bytes.push_back(o_tx_data);
        start_cnt++;
        last_start_cyc = cyc;
        if (!prev_busy) fstart.push_back(cyc);
      end
      if (o_frame_done) done_cnt++;
      if (o_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (o_busy && !o_tx_start && bytes.size() > 0 && o_tx_data !== bytes[bytes.size()-1]) hold_bad++;
    end
    prev_busy = o_busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    bytes.delete();
    fstart.delete();
    start_cnt = 0;
    done_cnt = 0;
    err_cnt = 0;
    hold_bad = 0;
  endtask

  task automatic pulse_send();
    i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && done_cnt < n; i++) @(negedge clk);
    check(tag, 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pre);
    check({pre, "_tx_data"}, 32'(o_tx_data), 32'h00);
    check({pre, "_tx_start"}, 32'(o_tx_start), 32'd0);
    check({pre, "_busy"}, 32'(o_busy), 32'd0);
    check({pre, "_frame_done"}, 32'(o_frame_done), 32'd0);
    check({pre, "_err"}, 32'(o_err), 32'd0);
  endtask

  initial begin
    int c0;
    int s0;
    rst = 1'b1;
    i_display_data = 16'h0000;
    i_send = 1'b0;
    i_auto_en = 1'b0;
    i_tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1234 with single-cycle request latency.
    clear_mon();
    i_display_data = 16'h1234;
    i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    check("lat_start", 32'(o_tx_start), 32'd1);
    check("lat_busy", 32'(o_busy), 32'd1);
    check("lat_data", 32'(o_tx_data), 32'h31);
    i_display_data = 16'hFFFF;
    wait_done(1, 300, "f1234_done_wait");
    repeat (20) @(negedge clk);
    check("f1234_nbytes", 32'(bytes.size()), 32'd7);
    for (int i = 0; i < 7; i++) check($sformatf("f1234_b%0d", i), 32'(bytes[i]), 32'(f1234[i]));
    check("f1234_done_cnt", 32'(done_cnt), 32'd1);
    check("f1234_err_cnt", 32'(err_cnt), 32'd0);
    check("f1234_hold", 32'(hold_bad), 32'd0);
    check("f1234_idle_busy", 32'(o_busy), 32'd0);

    // Frame 9AF0: non-decimal nibbles become dashes.
    clear_mon();
    i_display_data = 16'h9AF0;
    pulse_send();
    wait_done(1, 300, "f9af0_done_wait");
    repeat (5) @(negedge clk);
    check("f9af0_nbytes", 32'(bytes.size()), 32'd7);
    for (int i = 0; i < 7; i++) check($sformatf("f9af0_b%0d", i), 32'(bytes[i]), 32'(f9af0[i]));

    // ACK timeout abort.
    clear_mon();
    tx_en = 1'b0;
    i_display_data = 16'h1234;
    pulse_send();
    for (int i = 0; i < 100 && err_cnt == 0; i++) @(negedge clk);
    check("to_err_seen", 32'(err_cnt), 32'd1);
    check("to_err_delay", 32'(err_cyc - last_start_cyc), 32'd17);
    check("to_busy_low", 32'(o_busy), 32'd0);
    @(negedge clk);
    check("to_err_pulse", 32'(o_err), 32'd0);
    repeat (30) @(negedge clk);
    check("to_start_cnt", 32'(start_cnt), 32'd1);
    check("to_done_cnt", 32'(done_cnt), 32'd0);
    check("to_err_cnt", 32'(err_cnt), 32'd1);
    tx_en = 1'b1;

    // Three requests during a frame collapse to one extra frame with fresh data.
    clear_mon();
    i_display_data = 16'h1234;
    pulse_send();
    repeat (5) @(negedge clk);
    i_display_data = 16'h5678;
    repeat (5) @(negedge clk);
    pulse_send();
    repeat (10) @(negedge clk);
    pulse_send();
    repeat (10) @(negedge clk);
    pulse_send();
    wait_done(2, 400, "pend_done_wait");
    repeat (150) @(negedge clk);
    check("pend_done_cnt", 32'(done_cnt), 32'd2);
    check("pend_nbytes", 32'(bytes.size()), 32'd14);
    for (int i = 0; i < 7; i++) check($sformatf("pend_f1_b%0d", i), 32'(bytes[i]), 32'(f1234[i]));
    for (int i = 0; i < 7; i++) check($sformatf("pend_f2_b%0d", i), 32'(bytes[i+7]), 32'(f5678[i]));
    check("pend_hold", 32'(hold_bad), 32'd0);

    // Periodic requests every 50 cycles with a fast transmitter.
    clear_mon();
    busy_len = 2;
    i_display_data = 16'h4321;
    c0 = cyc;
    i_auto_en = 1'b1;
    repeat (180) @(negedge clk);
    i_auto_en = 1'b0;
    check("auto_nframes", 32'(fstart.size()), 32'd3);
    check("auto_first", 32'(fstart[0] - c0), 32'd50);
    check("auto_period1", 32'(fstart[1] - fstart[0]), 32'd50);
    check("auto_period2", 32'(fstart[2] - fstart[1]), 32'd50);
    repeat (150) @(negedge clk);
    check("auto_off_nframes", 32'(fstart.size()), 32'd3);
    check("auto_off_done", 32'(done_cnt), 32'd3);
    busy_len = 10;

    // Reset during byte index 3.
    clear_mon();
    i_display_data = 16'h1234;
    pulse_send();
    for (int i = 0; i < 200 && start_cnt < 4; i++) @(negedge clk);
    check("rst_reached_b3", 32'(start_cnt), 32'd4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    s0 = start_cnt;
    repeat (100) @(negedge clk);
    check("midrst_no_start", 32'(start_cnt), 32'(s0));
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_idle", 32'(o_busy), 32'd0);
    clear_mon();
    i_display_data = 16'h9AF0;
    pulse_send();
    wait_done(1, 300, "post_rst_done_wait");
    repeat (5) @(negedge clk);
    for (int i = 0; i < 7; i++) check($sformatf("post_rst_b%0d", i), 32'(bytes[i]), 32'(f9af0[i]));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
